// File: rtl/stopwatch_datapath_if.sv
// Controller-to-datapath strobe bundle plus the registered display and overflow returned to the controller side.
interface stopwatch_datapath_if;
  logic        clr;
  logic        count;
  logic        save;
  logic        disp;
  logic [15:0] disp_bcd;
  logic        ovf;

  modport master (output clr, count, save, disp, input disp_bcd, ovf);
  modport slave  (input clr, count, save, disp, output disp_bcd, ovf);
endinterface

// File: rtl/stopwatch_datapath.sv
// Prescaled 4-digit BCD stopwatch time with a lap register; disp_bcd is registered one cycle behind live/lap/disp.
// No backpressure: every strobe is sampled on every edge.
module stopwatch_datapath #(
  parameter int TICK_DIV = 500000
) (
  input  logic                 clk,
  input  logic                 reset,
  stopwatch_datapath_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;
  logic [15:0]   live;
  logic [15:0]   lap;
  logic [15:0]   disp_q;
  logic          ovf_q;

  logic [15:0]   live_inc;
  logic          carry;
  logic          wrap;
  logic          tick;

  assign tick = bus.count && (pre == PRE_MAX);

  // Ripple +0.01 s through the digits; a carry out of the 10 s digit is the 99.99 -> 00.00 wrap.
  always_comb begin
    live_inc = live;
    carry    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (live[4*i +: 4] == 4'd9) begin
          live_inc[4*i +: 4] = 4'd0;
        end else begin
          live_inc[4*i +: 4] = live[4*i +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre    <= '0;
      live   <= '0;
      lap    <= '0;
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      disp_q <= bus.disp ? lap : live;
      if (bus.clr) begin
        pre   <= '0;
        live  <= '0;
        lap   <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (bus.count) begin
          if (tick) begin
            pre  <= '0;
            live <= live_inc;
            if (wrap) begin
              ovf_q <= 1'b1;
            end
          end else begin
            pre <= pre + PW'(1);
          end
        end
        // Captures the pre-edge value, so a coincident tick is not seen by the lap.
        if (bus.save) begin
          lap <= live;
        end
      end
    end
  end

  assign bus.disp_bcd = disp_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_stopwatch_datapath.sv
module tb_stopwatch_datapath;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  stopwatch_datapath_if i4 ();
  stopwatch_datapath_if i1 ();

  stopwatch_datapath #(.TICK_DIV(4)) d4 (.clk(clk), .reset(reset), .bus(i4));
  stopwatch_datapath #(.TICK_DIV(1)) d1 (.clk(clk), .reset(reset), .bus(i1));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    {i4.clr, i4.count, i4.save, i4.disp} = 4'b0;
    {i1.clr, i1.count, i1.save, i1.disp} = 4'b0;
    step(2);
    chk("rst_disp4", i4.disp_bcd, 16'h0000);
    chk("rst_ovf4", {15'd0, i4.ovf}, 16'h0000);
    chk("rst_disp1", i1.disp_bcd, 16'h0000);
    reset = 1'b0;

    // 40 counting cycles at TICK_DIV=4 give ten ticks
    i4.count = 1'b1; step(40);
    chk("cnt40_lag", i4.disp_bcd, 16'h0009);
    i4.count = 1'b0; step(1);
    chk("cnt40", i4.disp_bcd, 16'h0010);
    chk("cnt40_ovf", {15'd0, i4.ovf}, 16'h0000);

    // clear, then phase preservation across a pause
    i4.clr = 1'b1; step(1); i4.clr = 1'b0;
    step(1);
    chk("clr_disp", i4.disp_bcd, 16'h0000);
    i4.count = 1'b1; step(6);
    i4.count = 1'b0; step(20);
    chk("pause_hold", i4.disp_bcd, 16'h0001);
    i4.count = 1'b1; step(1);
    chk("resume1", i4.disp_bcd, 16'h0001);
    step(1);
    chk("resume2_no_early", i4.disp_bcd, 16'h0001);
    i4.count = 1'b0; step(1);
    chk("resume_tick", i4.disp_bcd, 16'h0002);

    // save on the edge that ticks 00.09 -> 00.10
    i4.count = 1'b1; step(31);
    i4.save = 1'b1; step(1);
    i4.count = 1'b0; i4.save = 1'b0;
    i4.disp = 1'b1; step(1);
    chk("lap_pre_tick", i4.disp_bcd, 16'h0009);
    i4.disp = 1'b0; step(1);
    chk("live_after_save", i4.disp_bcd, 16'h0010);
    i4.save = 1'b1; step(1); i4.save = 1'b0;
    i4.disp = 1'b1; step(1);
    chk("save_paused", i4.disp_bcd, 16'h0010);
    i4.disp = 1'b0;

    // clr beats count and save at 00.37 with the prescaler mid-phase
    i4.clr = 1'b1; step(1); i4.clr = 1'b0;
    i4.count = 1'b1; step(148);
    i4.count = 1'b0; step(1);
    chk("at_0037", i4.disp_bcd, 16'h0037);
    i4.count = 1'b1; step(2);
    i4.clr = 1'b1; i4.save = 1'b1; step(1);
    i4.clr = 1'b0; i4.save = 1'b0; i4.count = 1'b0; step(1);
    chk("clr_prio_live", i4.disp_bcd, 16'h0000);
    i4.disp = 1'b1; step(1);
    chk("clr_prio_lap", i4.disp_bcd, 16'h0000);
    chk("clr_prio_ovf", {15'd0, i4.ovf}, 16'h0000);
    i4.disp = 1'b0;
    i4.count = 1'b1; step(3);
    i4.count = 1'b0; step(1);
    chk("pre_cleared", i4.disp_bcd, 16'h0000);
    i4.count = 1'b1; step(1);
    i4.count = 1'b0; step(1);
    chk("first_tick_after_clr", i4.disp_bcd, 16'h0001);

    // TICK_DIV=1 full range and overflow
    i1.count = 1'b1; step(9999);
    i1.count = 1'b0; step(1);
    chk("full_9999", i1.disp_bcd, 16'h9999);
    chk("ovf_before_wrap", {15'd0, i1.ovf}, 16'h0000);
    i1.save = 1'b1; step(1); i1.save = 1'b0;
    i1.count = 1'b1; step(1); i1.count = 1'b0;
    chk("ovf_on_wrap", {15'd0, i1.ovf}, 16'h0001);
    step(1);
    chk("wrap_live", i1.disp_bcd, 16'h0000);
    step(4);
    chk("ovf_sticky", {15'd0, i1.ovf}, 16'h0001);
    i1.disp = 1'b1; step(1);
    chk("lap_9999", i1.disp_bcd, 16'h9999);
    i1.disp = 1'b0;
    i1.clr = 1'b1; step(1); i1.clr = 1'b0;
    chk("ovf_clr", {15'd0, i1.ovf}, 16'h0000);
    i1.disp = 1'b1; step(1);
    chk("lap_clr", i1.disp_bcd, 16'h0000);
    i1.disp = 1'b0; step(1);
    chk("live_clr", i1.disp_bcd, 16'h0000);

    // asynchronous reset while counting at 12.34 with lap 05.00
    i4.clr = 1'b1; step(1); i4.clr = 1'b0;
    i4.count = 1'b1; step(2000);
    i4.count = 1'b0; i4.save = 1'b1; step(1); i4.save = 1'b0;
    i4.count = 1'b1; step(2936);
    i4.count = 1'b0; step(1);
    chk("at_1234", i4.disp_bcd, 16'h1234);
    i4.disp = 1'b1; step(1);
    chk("lap_0500", i4.disp_bcd, 16'h0500);
    i4.disp = 1'b0; i4.count = 1'b1; step(1);
    chk("pre_rst_disp", i4.disp_bcd, 16'h1234);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_disp", i4.disp_bcd, 16'h0000);
    chk("async_rst_ovf", {15'd0, i4.ovf}, 16'h0000);
    step(1);
    chk("rst_held_disp", i4.disp_bcd, 16'h0000);
    reset = 1'b0;
    i4.disp = 1'b1; step(1);
    chk("rst_lap", i4.disp_bcd, 16'h0000);
    i4.disp = 1'b0; step(4);
    chk("restart_tick", i4.disp_bcd, 16'h0001);
    chk("restart_ovf", {15'd0, i4.ovf}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
